plane_dispatch_scheduler: RTL and testbench

Schedules queued flash commands from the FTL onto flash planes. It keeps a pending count per (host, plane) pair, capped at QD = 22 entries, and a busy bitmap per plane. It picks the next host for each free plane round-robin, issues one dispatch at a time to the FMC side, and clears a plane's busy bit on FMC completion. It sits between the FTL request path and the bitmap/queue SRAM manager, and decides which host-plane queue is served next.

---
 rtl/plane_dispatch_scheduler_pkg.sv | 34 +++
 rtl/plane_dispatch_scheduler_if.sv | 32 +++
 rtl/plane_dispatch_scheduler_rr_arbiter.sv | 30 +++
 rtl/plane_dispatch_scheduler.sv | 135 +++++++++++++
 tb/tb_plane_dispatch_scheduler.sv | 370 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/plane_dispatch_scheduler_pkg.sv
// Shared sizing, id/counter types, FSM encoding and pointer-wrap helpers for the
// plane dispatch scheduler.
package plane_dispatch_scheduler_pkg;

  localparam int unsigned MAX_HOST_NUMBER    = 4;
  localparam int unsigned MAX_PLANE_NUMBER   = 8;
  localparam int unsigned QUEUE_DEPTH        = 22;
  localparam int unsigned HOST_ID_BIT_WIDTH  = $clog2(MAX_HOST_NUMBER);
  localparam int unsigned PLANE_ID_BIT_WIDTH = $clog2(MAX_PLANE_NUMBER);
  localparam int unsigned CNT_BIT_WIDTH      = $clog2(QUEUE_DEPTH + 1);

  localparam int unsigned IDX_IDLE  = 0;
  localparam int unsigned IDX_SCAN  = 1;
  localparam int unsigned IDX_ISSUE = 2;

  typedef logic [HOST_ID_BIT_WIDTH-1:0]  host_id_t;
  typedef logic [PLANE_ID_BIT_WIDTH-1:0] plane_id_t;
  typedef logic [CNT_BIT_WIDTH-1:0]      cnt_t;

  typedef enum logic [2:0] {
    StIdle  = 3'(1 << IDX_IDLE),
    StScan  = 3'(1 << IDX_SCAN),
    StIssue = 3'(1 << IDX_ISSUE)
  } state_e;

  function automatic plane_id_t next_plane(input plane_id_t p);
    return (p == plane_id_t'(MAX_PLANE_NUMBER - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic host_id_t next_host(input host_id_t h);
    return (h == host_id_t'(MAX_HOST_NUMBER - 1)) ? '0 : h + 1'b1;
  endfunction

endpackage

// File: rtl/plane_dispatch_scheduler_if.sv
// FTL enqueue, FMC dispatch/completion and status signals of the plane dispatch scheduler.
interface plane_dispatch_scheduler_if;
  import plane_dispatch_scheduler_pkg::*;

  logic                        i_req_valid;
  logic                        o_req_ready;
  host_id_t                    i_req_host_id;
  plane_id_t                   i_req_plane_id;
  logic                        o_disp_valid;
  logic                        i_disp_ready;
  host_id_t                    o_disp_host_id;
  plane_id_t                   o_disp_plane_id;
  logic                        i_done_valid;
  plane_id_t                   i_done_plane_id;
  logic [MAX_PLANE_NUMBER-1:0] o_plane_busy;
  logic                        o_idle;

  modport slave (
    input  i_req_valid, i_req_host_id, i_req_plane_id, i_disp_ready,
           i_done_valid, i_done_plane_id,
    output o_req_ready, o_disp_valid, o_disp_host_id, o_disp_plane_id,
           o_plane_busy, o_idle
  );

  modport master (
    output i_req_valid, i_req_host_id, i_req_plane_id, i_disp_ready,
           i_done_valid, i_done_plane_id,
    input  o_req_ready, o_disp_valid, o_disp_host_id, o_disp_plane_id,
           o_plane_busy, o_idle
  );

endinterface

// File: rtl/plane_dispatch_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr,
// wrapping around, by searching a double-width request vector.
module plane_dispatch_scheduler_rr_arbiter #(
  parameter int unsigned N   = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant,
  output logic          any_grant
);

  logic [N-1:0]   hi_mask;
  logic [2*N-1:0] dbl;

  always_comb begin
    hi_mask = '0;
    for (int unsigned i = 0; i < N; i++) begin
      hi_mask[i] = (IW'(i) >= ptr);
    end
    // Low half holds requesters at/after ptr, high half the wrapped copy.
    dbl       = {req, req & hi_mask};
    any_grant = |req;
    grant     = '0;
    for (int i = 2 * N - 1; i >= 0; i--) begin
      if (dbl[i]) grant = IW'(i % N);
    end
  end

endmodule

// File: rtl/plane_dispatch_scheduler.sv
// Per (host, plane) pending counters and plane busy bitmap; scans planes and issues one
// round-robin dispatch at a time to the FMC.
module plane_dispatch_scheduler
  import plane_dispatch_scheduler_pkg::*;
(
  input logic                       i_clk,
  input logic                       i_rst_n,
  plane_dispatch_scheduler_if.slave bus
);

  state_e                      state_q;
  cnt_t                        cnt_q [MAX_HOST_NUMBER][MAX_PLANE_NUMBER];
  logic [MAX_PLANE_NUMBER-1:0] busy_q, busy_d;
  plane_id_t                   scan_ptr_q, disp_plane_q;
  host_id_t                    host_ptr_q [MAX_PLANE_NUMBER];
  host_id_t                    disp_host_q;
  logic                        disp_valid_q;

  logic                        req_fire, disp_fire, any_pending, eligible, any_grant;
  logic [MAX_HOST_NUMBER-1:0]  scan_req;
  host_id_t                    grant_host;
  logic [MAX_HOST_NUMBER-1:0][MAX_PLANE_NUMBER-1:0] inc, dec;

  assign bus.o_req_ready = (cnt_q[bus.i_req_host_id][bus.i_req_plane_id] != cnt_t'(QUEUE_DEPTH));
  assign req_fire        = bus.i_req_valid && bus.o_req_ready;
  assign disp_fire       = disp_valid_q && bus.i_disp_ready;

  always_comb begin
    any_pending = 1'b0;
    scan_req    = '0;
    for (int h = 0; h < MAX_HOST_NUMBER; h++) begin
      scan_req[h] = (cnt_q[h][scan_ptr_q] != '0);
      for (int p = 0; p < MAX_PLANE_NUMBER; p++) begin
        if (cnt_q[h][p] != '0) any_pending = 1'b1;
      end
    end
  end

  plane_dispatch_scheduler_rr_arbiter #(
    .N (MAX_HOST_NUMBER)
  ) u_rr_arbiter (
    .req       (scan_req),
    .ptr       (host_ptr_q[scan_ptr_q]),
    .grant     (grant_host),
    .any_grant (any_grant)
  );

  assign eligible = !busy_q[scan_ptr_q] && any_grant;

  always_comb begin
    inc = '0;
    dec = '0;
    if (req_fire)  inc[bus.i_req_host_id][bus.i_req_plane_id] = 1'b1;
    if (disp_fire) dec[disp_host_q][disp_plane_q] = 1'b1;
  end

  // Enqueue and dispatch on the same counter cancel out.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int h = 0; h < MAX_HOST_NUMBER; h++) begin
        for (int p = 0; p < MAX_PLANE_NUMBER; p++) cnt_q[h][p] <= '0;
      end
    end else begin
      for (int h = 0; h < MAX_HOST_NUMBER; h++) begin
        for (int p = 0; p < MAX_PLANE_NUMBER; p++) begin
          case ({inc[h][p], dec[h][p]})
            2'b10:   cnt_q[h][p] <= cnt_q[h][p] + cnt_t'(1);
            2'b01:   cnt_q[h][p] <= cnt_q[h][p] - cnt_t'(1);
            default: cnt_q[h][p] <= cnt_q[h][p];
          endcase
        end
      end
    end
  end

  // Set after clear so a dispatch wins over a same-cycle completion.
  always_comb begin
    busy_d = busy_q;
    if (bus.i_done_valid) busy_d[bus.i_done_plane_id] = 1'b0;
    if (disp_fire)        busy_d[disp_plane_q] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) busy_q <= '0;
    else          busy_q <= busy_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= StIdle;
      scan_ptr_q   <= '0;
      disp_valid_q <= 1'b0;
      disp_host_q  <= '0;
      disp_plane_q <= '0;
      for (int p = 0; p < MAX_PLANE_NUMBER; p++) host_ptr_q[p] <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_pending) state_q <= StScan;
        end
        StScan: begin
          if (eligible) begin
            disp_host_q  <= grant_host;
            disp_plane_q <= scan_ptr_q;
            disp_valid_q <= 1'b1;
            state_q      <= StIssue;
          end else if (any_pending) begin
            scan_ptr_q <= next_plane(scan_ptr_q);
          end else begin
            state_q <= StIdle;
          end
        end
        StIssue: begin
          if (bus.i_disp_ready) begin
            disp_valid_q             <= 1'b0;
            host_ptr_q[disp_plane_q] <= next_host(disp_host_q);
            scan_ptr_q               <= next_plane(disp_plane_q);
            state_q                  <= StScan;
          end
        end
        default: begin
          disp_valid_q <= 1'b0;
          state_q      <= StIdle;
        end
      endcase
    end
  end

  assign bus.o_disp_valid    = disp_valid_q;
  assign bus.o_disp_host_id  = disp_host_q;
  assign bus.o_disp_plane_id = disp_plane_q;
  assign bus.o_plane_busy    = busy_q;
  assign bus.o_idle          = (state_q == StIdle) && (busy_q == '0) && !any_pending;

endmodule

// File: tb/tb_plane_dispatch_scheduler.sv
// Scoreboard bench: directed scenarios plus randomized traffic against a queue/array model
// of pending counts, busy planes and round-robin pointers.
module tb_plane_dispatch_scheduler;
  import plane_dispatch_scheduler_pkg::*;

  localparam int NH = MAX_HOST_NUMBER;
  localparam int NP = MAX_PLANE_NUMBER;
  localparam int QD = QUEUE_DEPTH;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  plane_dispatch_scheduler_if bus ();

  plane_dispatch_scheduler dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int h;
    int p;
  } disp_t;

  int    n_cmp;
  int    n_err;
  int    m_cnt [NH][NP];
  bit    m_busy [NP];
  int    m_hptr [NP];
  int    m_scan;
  disp_t exp_q [$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int h = 0; h < NH; h++) for (int p = 0; p < NP; p++) m_cnt[h][p] = 0;
    for (int p = 0; p < NP; p++) begin
      m_busy[p] = 1'b0;
      m_hptr[p] = 0;
    end
    m_scan = 0;
    exp_q.delete();
  endtask

  function automatic int pending_total();
    int s = 0;
    for (int h = 0; h < NH; h++) for (int p = 0; p < NP; p++) s += m_cnt[h][p];
    return s;
  endfunction

  function automatic int plane_pending(input int p);
    int s = 0;
    for (int h = 0; h < NH; h++) s += m_cnt[h][p];
    return s;
  endfunction

  // First free plane with work from the scan position, then first host from that plane's pointer.
  function automatic bit predict(output int h, output int p);
    h = 0;
    p = 0;
    for (int k = 0; k < NP; k++) begin
      int pp = (m_scan + k) % NP;
      if (!m_busy[pp] && plane_pending(pp) > 0) begin
        for (int j = 0; j < NH; j++) begin
          int hh = (m_hptr[pp] + j) % NH;
          if (m_cnt[hh][pp] > 0) begin
            h = hh;
            p = pp;
            return 1'b1;
          end
        end
      end
    end
    return 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input int h, input int p);
    bus.i_req_valid    = 1'b1;
    bus.i_req_host_id  = HOST_ID_BIT_WIDTH'(h);
    bus.i_req_plane_id = PLANE_ID_BIT_WIDTH'(p);
    @(negedge clk);
    check("req_ready", int'(bus.o_req_ready), int'(m_cnt[h][p] != QD));
    if (m_cnt[h][p] != QD) m_cnt[h][p]++;
    tick();
    bus.i_req_valid = 1'b0;
  endtask

  task automatic done(input int p);
    bus.i_done_valid    = 1'b1;
    bus.i_done_plane_id = PLANE_ID_BIT_WIDTH'(p);
    tick();
    bus.i_done_valid = 1'b0;
    m_busy[p]        = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.o_disp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("disp_valid_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.o_idle) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_reached", int'(ok), 1);
    tick();
  endtask

  task automatic model_dispatch(input int h, input int p);
    m_cnt[h][p]--;
    m_busy[p] = 1'b1;
    m_hptr[p] = (h + 1) % NH;
    m_scan    = (p + 1) % NP;
  endtask

  task automatic push_exp(input int h, input int p);
    disp_t e;
    e.h = h;
    e.p = p;
    exp_q.push_back(e);
  endtask

  task automatic handshake(input int h, input int p);
    bus.i_disp_ready = 1'b1;
    tick();
    bus.i_disp_ready = 1'b0;
    model_dispatch(h, p);
  endtask

  task automatic serve(input int h, input int p);
    bit ok;
    push_exp(h, p);
    wait_valid(ok);
    if (!ok) begin
      void'(exp_q.pop_back());
      return;
    end
    tick();
    handshake(h, p);
  endtask

  task automatic serve_rand();
    int h, p;
    bit found = 1'b0;
    bit ok;
    for (int k = 0; k < 20 && !found; k++) begin
      found = predict(h, p);
      if (!found) begin
        if (pending_total() > 0) begin
          for (int q = 0; q < NP; q++) begin
            if (m_busy[q] && plane_pending(q) > 0) begin
              done(q);
              break;
            end
          end
        end else begin
          enq($urandom_range(0, NH - 1), $urandom_range(0, NP - 1));
        end
      end
    end
    if (!found) return;
    push_exp(h, p);
    wait_valid(ok);
    if (!ok) begin
      void'(exp_q.pop_back());
      return;
    end
    tick();
    repeat ($urandom_range(0, 3)) begin
      case ($urandom_range(0, 2))
        0:       enq($urandom_range(0, NH - 1), $urandom_range(0, NP - 1));
        1:       done($urandom_range(0, NP - 1));
        default: tick();
      endcase
    end
    handshake(h, p);
  endtask

  task automatic monitor();
    disp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.o_disp_valid && bus.i_disp_ready) begin
        if (exp_q.size() == 0) begin
          check("disp_unexpected", int'(bus.o_disp_plane_id), -1);
        end else begin
          e = exp_q.pop_front();
          check("disp_host", int'(bus.o_disp_host_id), e.h);
          check("disp_plane", int'(bus.o_disp_plane_id), e.p);
        end
      end
    end
  endtask

  initial begin
    bit ok;
    bus.i_req_valid     = 1'b0;
    bus.i_req_host_id   = '0;
    bus.i_req_plane_id  = '0;
    bus.i_disp_ready    = 1'b0;
    bus.i_done_valid    = 1'b0;
    bus.i_done_plane_id = '0;
    n_cmp = 0;
    n_err = 0;
    model_reset();
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("rst_disp_valid", int'(bus.o_disp_valid), 0);
    check("rst_disp_host", int'(bus.o_disp_host_id), 0);
    check("rst_disp_plane", int'(bus.o_disp_plane_id), 0);
    check("rst_busy", int'(bus.o_plane_busy), 0);
    check("rst_idle", int'(bus.o_idle), 1);
    rst_n = 1'b1;
    tick();

    // Move the scan pointer to plane 3 with one dispatch on plane 2.
    enq(0, 2);
    serve(0, 2);
    @(negedge clk);
    check("busy_plane2", int'(bus.o_plane_busy), 8'h04);
    tick();
    done(2);
    wait_idle();

    // Enqueue (1,3) at cycle N: valid must appear exactly at N+3.
    enq(1, 3);
    @(negedge clk);
    check("lat_n1_valid", int'(bus.o_disp_valid), 0);
    @(negedge clk);
    check("lat_n2_valid", int'(bus.o_disp_valid), 0);
    @(negedge clk);
    check("lat_n3_valid", int'(bus.o_disp_valid), 1);
    push_exp(1, 3);
    tick();
    handshake(1, 3);
    @(negedge clk);
    check("busy_plane3", int'(bus.o_plane_busy), 8'h08);
    tick();
    done(3);
    @(negedge clk);
    check("busy_cleared_d1", int'(bus.o_plane_busy), 0);
    wait_idle();

    // Round-robin among hosts 0,1,2 on plane 5.
    enq(0, 5);
    enq(1, 5);
    enq(2, 5);
    serve(0, 5);
    done(5);
    serve(1, 5);
    done(5);
    serve(2, 5);
    done(5);
    enq(0, 5);
    serve(0, 5);
    done(5);
    wait_idle();

    // Busy plane must hold back its pending request until completion.
    enq(0, 2);
    serve(0, 2);
    enq(1, 2);
    ok = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.o_disp_valid) ok = 1'b1;
    end
    check("no_disp_while_busy", int'(ok), 0);
    tick();
    done(2);
    serve(1, 2);
    done(2);
    wait_idle();

    // Spurious completion on an idle plane.
    done(6);
    @(negedge clk);
    check("spurious_busy", int'(bus.o_plane_busy), 0);
    check("spurious_idle", int'(bus.o_idle), 1);
    tick();

    // Enqueue and dispatch on (2,4) in the same cycle leave the counter at 1.
    enq(2, 4);
    push_exp(2, 4);
    wait_valid(ok);
    tick();
    bus.i_disp_ready   = 1'b1;
    bus.i_req_valid    = 1'b1;
    bus.i_req_host_id  = HOST_ID_BIT_WIDTH'(2);
    bus.i_req_plane_id = PLANE_ID_BIT_WIDTH'(4);
    @(negedge clk);
    check("same_cycle_ready", int'(bus.o_req_ready), 1);
    tick();
    bus.i_disp_ready = 1'b0;
    bus.i_req_valid  = 1'b0;
    m_busy[4] = 1'b1;
    m_hptr[4] = 3;
    m_scan    = 5;
    done(4);
    serve(2, 4);
    done(4);
    wait_idle();

    repeat (150) serve_rand();

    // Fill (0,0) with the FMC stalled; the 23rd attempt must be refused.
    if (m_busy[0]) done(0);
    while (m_cnt[0][0] < QD) enq(0, 0);
    enq(0, 0);
    enq(0, 0);
    check("full_count_model", m_cnt[0][0], QD);

    // Reset while a dispatch is being offered.
    wait_valid(ok);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_disp_valid", int'(bus.o_disp_valid), 0);
    check("rst_mid_busy", int'(bus.o_plane_busy), 0);
    check("rst_mid_idle", int'(bus.o_idle), 1);
    bus.i_req_host_id  = '0;
    bus.i_req_plane_id = '0;
    #1;
    check("rst_mid_ready00", int'(bus.o_req_ready), 1);
    model_reset();
    tick();
    rst_n = 1'b1;
    tick();

    enq(3, 7);
    serve(3, 7);
    done(7);
    wait_idle();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
